// File: rtl/dda_pkg.sv
// Shared register map, FSM state encoding and reset defaults for the DDA step controller.
package dda_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_IC_X   = 3'd1;
  localparam logic [2:0] ADDR_IC_V   = 3'd2;
  localparam logic [2:0] ADDR_B      = 3'd3;
  localparam logic [2:0] ADDR_K      = 3'd4;
  localparam logic [2:0] ADDR_STEPS  = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_FRAMES = 3'd7;

  localparam int CTRL_RUN_BIT       = 0;
  localparam int CTRL_RESTART_BIT   = 1;
  localparam int STATUS_OVERRUN_BIT = 3;

  localparam int DEFAULT_STEPS = 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_DDA  = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_STEP       = 3'd3,
    ST_EMIT       = 3'd4
  } dda_state_t;

endpackage

// File: rtl/dda_regfile.sv
// NIOS-facing register file: CTRL decode, shadow parameter registers, sticky overrun and read mux.
module dda_regfile
  import dda_pkg::*;
#(
  parameter int PARAM_W = 18,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         avs_address,
  input  logic               avs_write,
  input  logic               avs_read,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  input  dda_state_t         state,
  input  logic [CNT_W-1:0]   frames,
  input  logic               overrun_set,
  output logic               run,
  output logic               restart,
  output logic               run_rise,
  output logic [PARAM_W-1:0] sh_ic_x,
  output logic [PARAM_W-1:0] sh_ic_v,
  output logic [PARAM_W-1:0] sh_b,
  output logic [PARAM_W-1:0] sh_k,
  output logic [CNT_W-1:0]   sh_steps
);

  logic        ctrl_wr;
  logic        overrun;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign ctrl_wr      = avs_write && (avs_address == ADDR_CTRL);
  assign restart      = ctrl_wr && avs_writedata[CTRL_RESTART_BIT];
  assign run_rise     = ctrl_wr && avs_writedata[CTRL_RUN_BIT] && !run;
  assign unused_wdata = ^avs_writedata[31:PARAM_W];

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_IC_X:   rd_mux[PARAM_W-1:0] = sh_ic_x;
      ADDR_IC_V:   rd_mux[PARAM_W-1:0] = sh_ic_v;
      ADDR_B:      rd_mux[PARAM_W-1:0] = sh_b;
      ADDR_K:      rd_mux[PARAM_W-1:0] = sh_k;
      ADDR_STEPS:  rd_mux[CNT_W-1:0]   = sh_steps;
      ADDR_STATUS: begin
        rd_mux[2:0]                = state;
        rd_mux[STATUS_OVERRUN_BIT] = overrun;
      end
      ADDR_FRAMES: rd_mux[CNT_W-1:0]   = frames;
      default:     rd_mux = '0;
    endcase
  end

  // Read data is registered from pre-write values, so a same-cycle write is not visible yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      run          <= 1'b0;
      overrun      <= 1'b0;
      sh_ic_x      <= '0;
      sh_ic_v      <= '0;
      sh_b         <= '0;
      sh_k         <= '0;
      sh_steps     <= CNT_W'(DEFAULT_STEPS);
      avs_readdata <= '0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          ADDR_CTRL:  run      <= avs_writedata[CTRL_RUN_BIT];
          ADDR_IC_X:  sh_ic_x  <= avs_writedata[PARAM_W-1:0];
          ADDR_IC_V:  sh_ic_v  <= avs_writedata[PARAM_W-1:0];
          ADDR_B:     sh_b     <= avs_writedata[PARAM_W-1:0];
          ADDR_K:     sh_k     <= avs_writedata[PARAM_W-1:0];
          ADDR_STEPS: sh_steps <= avs_writedata[CNT_W-1:0];
          default:    ;
        endcase
      end
      // A new overrun event wins over a clearing write in the same cycle so it is never lost.
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (avs_write && (avs_address == ADDR_STATUS)) begin
        overrun <= 1'b0;
      end
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
    end
  end

endmodule

// File: rtl/dda_step_ctrl.sv
// Frame-synchronous DDA stepping controller: one DDA step per emitted trace sample, STEPS samples per frame.
module dda_step_ctrl
  import dda_pkg::*;
#(
  parameter int PARAM_W = 18,
  parameter int XS_W    = 9,
  parameter int CNT_W   = 16
) (
  input  logic                      clk0_020,
  input  logic                      rst,
  input  logic [2:0]                avs_address,
  input  logic                      avs_write,
  input  logic                      avs_read,
  input  logic [31:0]               avs_writedata,
  output logic [31:0]               avs_readdata,
  input  logic                      vsync_pulse,
  input  logic [XS_W-1:0]           x_shift,
  output logic                      clk_en,
  output logic                      dda_rst,
  output logic signed [PARAM_W-1:0] initial_condition_x,
  output logic signed [PARAM_W-1:0] initial_condition_v,
  output logic signed [PARAM_W-1:0] B,
  output logic signed [PARAM_W-1:0] k,
  output logic                      sample_valid,
  output logic [XS_W-1:0]           sample_data,
  input  logic                      sample_ready
);

  dda_state_t         state, state_next;
  logic               run, restart, run_rise;
  logic [PARAM_W-1:0] sh_ic_x, sh_ic_v, sh_b, sh_k;
  logic [CNT_W-1:0]   sh_steps, steps_act, step_cnt, frames;
  logic               rst_cnt;
  logic               accept_vsync, overrun_set, load_params;
  logic               first_q;
  logic [XS_W-1:0]    sample_q;

  dda_regfile #(
    .PARAM_W (PARAM_W),
    .CNT_W   (CNT_W)
  ) u_regfile (
    .clk           (clk0_020),
    .rst           (rst),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_read      (avs_read),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .state         (state),
    .frames        (frames),
    .overrun_set   (overrun_set),
    .run           (run),
    .restart       (restart),
    .run_rise      (run_rise),
    .sh_ic_x       (sh_ic_x),
    .sh_ic_v       (sh_ic_v),
    .sh_b          (sh_b),
    .sh_k          (sh_k),
    .sh_steps      (sh_steps)
  );

  // Restart is checked first in every state so it overrides vsync and run changes.
  always_comb begin
    state_next   = state;
    accept_vsync = 1'b0;
    overrun_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (restart || run_rise) state_next = ST_RESET_DDA;
      end
      ST_RESET_DDA: begin
        if (restart)      state_next = ST_RESET_DDA;
        else if (rst_cnt) state_next = run ? ST_WAIT_FRAME : ST_IDLE;
      end
      ST_WAIT_FRAME: begin
        if (restart)          state_next = ST_RESET_DDA;
        else if (!run)        state_next = ST_IDLE;
        else if (vsync_pulse) begin
          accept_vsync = 1'b1;
          state_next   = (sh_steps != '0) ? ST_STEP : ST_WAIT_FRAME;
        end
      end
      ST_STEP: begin
        overrun_set = vsync_pulse;
        state_next  = restart ? ST_RESET_DDA : ST_EMIT;
      end
      ST_EMIT: begin
        overrun_set = vsync_pulse;
        if (restart) state_next = ST_RESET_DDA;
        else if (sample_ready) begin
          if (!run)                       state_next = ST_IDLE;
          else if (step_cnt < steps_act)  state_next = ST_STEP;
          else                            state_next = ST_WAIT_FRAME;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign load_params = ((state == ST_RESET_DDA) && !rst_cnt) || accept_vsync;

  always_ff @(posedge clk0_020) begin
    if (rst) begin
      state               <= ST_IDLE;
      rst_cnt             <= 1'b0;
      step_cnt            <= '0;
      frames              <= '0;
      steps_act           <= CNT_W'(DEFAULT_STEPS);
      initial_condition_x <= '0;
      initial_condition_v <= '0;
      B                   <= '0;
      k                   <= '0;
      first_q             <= 1'b0;
      sample_q            <= '0;
    end else begin
      state   <= state_next;
      rst_cnt <= (state == ST_RESET_DDA) && !restart;
      if (load_params) begin
        initial_condition_x <= $signed(sh_ic_x);
        initial_condition_v <= $signed(sh_ic_v);
        B                   <= $signed(sh_b);
        k                   <= $signed(sh_k);
        steps_act           <= sh_steps;
        step_cnt            <= '0;
      end else if (state == ST_STEP) begin
        step_cnt <= step_cnt + 1'b1;
      end
      if (accept_vsync) frames <= frames + 1'b1;
      first_q <= (state == ST_STEP) && (state_next == ST_EMIT);
      if (first_q) sample_q <= x_shift;
    end
  end

  // The DDA only settles after the step edge, so the entry cycle forwards x_shift live and then holds it.
  assign clk_en       = !rst && ((state == ST_RESET_DDA) || (state == ST_STEP));
  assign dda_rst      = rst || (state == ST_RESET_DDA);
  assign sample_valid = !rst && (state == ST_EMIT);
  assign sample_data  = rst ? '0 : (first_q ? x_shift : sample_q);

endmodule
